// File: rtl/user_io_event_queue_if.sv
// Event stream between the user I/O event queue and the host register stage.
// valid/ready: a word transfers on any clock where evt_valid && evt_ready; valid never waits on ready.
interface user_io_event_queue_if;
  logic       evt_valid;
  logic [7:0] evt_data;
  logic       evt_ready;
  logic [3:0] evt_count;

  modport master (output evt_valid, output evt_data, output evt_count, input evt_ready);
  modport slave  (input evt_valid, input evt_data, input evt_count, output evt_ready);
endinterface

// File: rtl/user_io_event_queue.sv
// Debounces raw button/link-power levels on a slow tick and queues one 8-bit
// event per accepted edge in a first-word-fall-through FIFO for the host.
module user_io_event_queue #(
    parameter int CLK_RATE_HZ  = 16_000_000,
    parameter int SAMPLE_HZ    = 1_000,
    parameter int STABLE_COUNT = 4,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic [5:0]                  i_button,
    input  logic [3:0]                  i_link_pow,
    output logic [5:0]                  o_button_db,
    output logic [3:0]                  o_link_pow_db,
    user_io_event_queue_if.master       evt,
    output logic                        o_overflow,
    output logic                        o_dbg_state
);

    localparam int TICK_DIV = CLK_RATE_HZ / SAMPLE_HZ;
    localparam int TW       = $clog2(TICK_DIV);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int NCH      = 10;

    typedef enum logic {S_IDLE, S_SCAN} state_t;

    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [NCH-1:0] raw_q, db, db_next, pending, set_mask, clr_mask;
    logic [3:0]     stab_cnt [NCH];
    logic [3:0]     stab_next [NCH];
    state_t         state, state_next;
    logic           push;
    logic [7:0]     evt_word;
    logic [3:0]     sel;

    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [3:0]     count;
    logic           full, do_push, do_pop;

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else tick_cnt <= tick_cnt + TW'(1);
    end

    // Channel order: buttons in bits 0-5, links in bits 6-9; also the scan priority.
    always_comb begin
        db_next  = db;
        set_mask = '0;
        for (int i = 0; i < NCH; i++) begin
            stab_next[i] = stab_cnt[i];
            if (tick) begin
                if (raw_q[i] == db[i]) begin
                    stab_next[i] = '0;
                end else if (stab_cnt[i] + 4'd1 == 4'(STABLE_COUNT)) begin
                    stab_next[i] = '0;
                    db_next[i]   = raw_q[i];
                    set_mask[i]  = 1'b1;
                end else begin
                    stab_next[i] = stab_cnt[i] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            raw_q   <= '0;
            db      <= '0;
            pending <= '0;
            for (int i = 0; i < NCH; i++) stab_cnt[i] <= '0;
        end else begin
            raw_q   <= {i_link_pow, i_button};
            db      <= db_next;
            pending <= (pending & ~clr_mask) | set_mask;
            for (int i = 0; i < NCH; i++) stab_cnt[i] <= stab_next[i];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= S_IDLE;
        else state <= state_next;
    end

    always_comb begin
        state_next = state;
        clr_mask   = '0;
        push       = 1'b0;
        evt_word   = '0;
        sel        = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pending[i]) sel = 4'(i);
        end
        case (state)
            S_IDLE: if (pending != '0) state_next = S_SCAN;
            S_SCAN: begin
                if (pending != '0) begin
                    push          = 1'b1;
                    clr_mask[sel] = 1'b1;
                    evt_word      = (sel < 4'd6) ? {1'b1, db[sel], 3'b000, sel[2:0]}
                                                 : {1'b0, db[sel], 3'b000, 3'(sel - 4'd6)};
                end
                if (((pending & ~clr_mask) | set_mask) == '0) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // A pop frees the head slot on the same edge, so a full FIFO still accepts a push then.
    assign full    = (count == 4'(FIFO_DEPTH));
    assign do_pop  = (count != 4'd0) && evt.evt_ready;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr] <= evt_word;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
            if (push && !do_push) o_overflow <= 1'b1;
        end
    end

    assign evt.evt_valid  = (count != 4'd0);
    assign evt.evt_data   = mem[rd_ptr];
    assign evt.evt_count  = count;
    assign o_button_db    = db[5:0];
    assign o_link_pow_db  = db[9:6];
    assign o_dbg_state    = (state == S_SCAN);

endmodule
